spi_slave_resp: RTL and testbench
=================================

Name: spi_slave_resp

Overview:
- SPI mode-0 responder (slave), the far end of the SPI master inside mcont.
- Used as an on-board loopback/test target for the protocol controllers; also lets a second board act as a peripheral.
- Oversamples sck/mosi/ss in the core clock domain, deserialises MOSI into bytes and serialises a host-supplied byte onto MISO, MSB first.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- SYNC_STAGES, 2, synchroniser flops on sck_i, mosi_i, ss_n_i (minimum 2).
- FIFO_DEPTH, 4, RX FIFO entries when SPIS_RXFIFO_EN is defined (power of 2).

Ports:
- clk  in  1  core clock (CLK_BUF domain); sck_i must be ≤ clk/8.
- nrst  in  1  asynchronous, active-low reset.
- sck_i  in  1  SPI clock from master, async.
- mosi_i  in  1  master-out data, async.
- ss_n_i  in  1  slave select, active low, async.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  tristate enable for MISO; 1 only while selected.
- tx_data  in  DATA_WIDTH  next byte to transmit.
- tx_valid  in  1  tx_data holds a byte.
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
- rx_data  out  DATA_WIDTH  received byte (head of FIFO/holding reg).
- rx_valid  out  1  rx_data valid; held until rx_ready.
- rx_ready  in  1  consumer pop; transfer when rx_valid & rx_ready.
- rx_overflow  out  1  sticky; set when a byte is dropped, cleared by reset or by rx_ready while rx_valid=0.
- tx_underrun  out  1  one-cycle pulse: load point reached with tx_valid=0.
- busy  out  1  1 while selected (synchronised ss low).

Behaviour:
- Reset: miso_o=0, miso_oe_o=0, tx_ready=0, rx_data=0, rx_valid=0, rx_overflow=0, tx_underrun=0, busy=0; FSM IDLE; bit counter 0; sync flops 1 (ss), 0 (sck, mosi).
- Edge detect on last two synchronised sck samples: rise=sample point, fall=shift point. Events are acted on SYNC_STAGES+1 clk cycles after the pin edge.
- FSM:
  - IDLE: waits for synced ss low -> LOAD.
  - LOAD (1 cycle): if tx_valid, tx_shift<=tx_data and tx_ready=1; else tx_shift<=all ones and tx_underrun=1. Sets bitcnt=0, miso_oe_o=1, miso_o=tx_shift MSB -> SHIFT.
  - SHIFT:
    - Rise: rx_shift<={rx_shift[W-2:0], mosi_sync}; bitcnt++.
    - When bitcnt reaches DATA_WIDTH on a rise: the byte is pushed to RX the same cycle and bitcnt<=0.
    - Fall with bitcnt==0 after a completed frame: reload tx_shift exactly as in LOAD (tx_ready or tx_underrun pulse).
    - Other falls: tx_shift<<1, miso_o<=new MSB.
    - Synced ss high -> IDLE.
- ss deasserts mid-frame: partial rx bits discarded, no push; the current tx byte is not re-sent. miso_oe_o=0 and miso_o=0 in the cycle IDLE is entered.
- ss deasserts exactly on the cycle of the 8th rise: the byte is pushed (frame counts as complete).
- RX push with storage full: new byte dropped, rx_overflow set, existing contents unchanged.
- Push and pop in the same cycle when full: both happen, no overflow.
- tx_ready never pulses while ss high; at most one pulse per frame.
- busy = synced ss low.

Optional Feature:
- SPIS_RXFIFO_EN defined: RX storage is a FIFO_DEPTH-entry FIFO. rx_data shows the head (first-word-fall-through). Overflow only when FIFO_DEPTH entries are held.
- Not defined: single holding register. A second byte arriving before the pop sets rx_overflow and is dropped. FIFO_DEPTH is ignored.
- Ports are identical in both builds.

Test Plan:
- Reset mid-frame: nrst low during bit 4 of a transfer -> all outputs at reset values immediately (async). After release and a new ss assert, the next frame is received cleanly.
- Single frame: tx_valid=1, tx_data=0xA5; master sends 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1. rx_data=0x3C with rx_valid within SYNC_STAGES+2 clk of the 8th rise; one tx_ready pulse.
- Back-to-back frames: master sends 0x01, 0x02, 0x03 under one ss; tx supplies 0x11, 0x22, 0x33 -> master reads 0x11, 0x22, 0x33. Three tx_ready pulses; rx pops 0x01, 0x02, 0x03 in order.
- Underrun: tx_valid=0 at ss fall -> MISO=0xFF, tx_underrun pulses once; rx still captures the MOSI byte.
- Abort: ss high after 5 bits of 0xF0 -> no rx_valid, miso_oe_o=0. The next full frame 0x5A is received as 0x5A.
- Overflow, rx_ready held 0:
  - With SPIS_RXFIFO_EN: 5 frames 0x10..0x14 -> FIFO holds 0x10..0x13, rx_overflow=1.
  - Without: 2 frames -> rx_data=0x10, rx_overflow=1.

Source files
------------

// File: rtl/spi_slave_resp_if.sv
// Bus bundle for spi_slave_resp: SPI pins plus the host-side TX/RX byte handshakes.
// The slave modport is the responder's view; master is the pin driver / byte host.
interface spi_slave_resp_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sck_i;
  logic                  mosi_i;
  logic                  ss_n_i;
  logic                  miso_o;
  logic                  miso_oe_o;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  rx_overflow;
  logic                  tx_underrun;
  logic                  busy;

  modport slave (
    input  sck_i, mosi_i, ss_n_i, tx_data, tx_valid, rx_ready,
    output miso_o, miso_oe_o, tx_ready, rx_data, rx_valid, rx_overflow, tx_underrun, busy
  );

  modport master (
    output sck_i, mosi_i, ss_n_i, tx_data, tx_valid, rx_ready,
    input  miso_o, miso_oe_o, tx_ready, rx_data, rx_valid, rx_overflow, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: oversampled pins, MSB-first shift in/out, byte handshakes.
// Define SPIS_RXFIFO_EN for a FIFO_DEPTH-entry RX FIFO instead of a single holding register.
module spi_slave_resp #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               nrst,
  spi_slave_resp_if.slave    bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic                   r_sckDly;

  logic                  w_sckS;
  logic                  w_mosiS;
  logic                  w_ssS;
  logic                  w_rise;
  logic                  w_fall;

  logic [DATA_WIDTH-1:0] r_txShift;
  logic [DATA_WIDTH-1:0] r_rxShift;
  logic [CW-1:0]         r_bitCnt;
  logic                  r_frameDone;
  logic                  r_miso;
  logic                  r_misoOe;
  logic                  r_overflow;

  logic                  w_load;
  logic                  w_goIdle;
  logic                  w_txReady;
  logic                  w_txUnderrun;
  logic                  w_shiftOut;
  logic                  w_sampleIn;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_rxValid;
  logic [DATA_WIDTH-1:0] w_rxHead;
  logic [DATA_WIDTH-1:0] w_rxByte;
  logic                  w_unused;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sckSync  <= '0;
      r_mosiSync <= '0;
      r_ssSync   <= '1;
      r_sckDly   <= 1'b0;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], bus.sck_i};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi_i};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], bus.ss_n_i};
      r_sckDly   <= w_sckS;
    end
  end

  assign w_sckS   = r_sckSync[SYNC_STAGES-1];
  assign w_mosiS  = r_mosiSync[SYNC_STAGES-1];
  assign w_ssS    = r_ssSync[SYNC_STAGES-1];
  assign w_rise   = w_sckS & ~r_sckDly;
  assign w_fall   = ~w_sckS & r_sckDly;
  assign w_rxByte = {r_rxShift[DATA_WIDTH-2:0], w_mosiS};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A fall seen together with ss deassertion is the master's trailing edge, so it never reloads.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_goIdle    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_ssS) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_ssS) begin
          w_nextState = ST_IDLE;
          w_goIdle    = 1'b1;
        end else begin
          w_nextState = ST_SHIFT;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ssS) begin
          w_nextState = ST_IDLE;
          w_goIdle    = 1'b1;
        end else if (w_fall && (r_bitCnt == '0) && r_frameDone) begin
          w_load = 1'b1;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    w_txReady    = w_load & bus.tx_valid;
    w_txUnderrun = w_load & ~bus.tx_valid;
  end

  assign w_shiftOut = (r_state == ST_SHIFT) && w_fall && !w_load && !w_ssS;
  assign w_sampleIn = (r_state == ST_SHIFT) && w_rise;
  assign w_push     = w_sampleIn && (r_bitCnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_txShift   <= '0;
      r_rxShift   <= '0;
      r_bitCnt    <= '0;
      r_frameDone <= 1'b0;
      r_miso      <= 1'b0;
      r_misoOe    <= 1'b0;
    end else if (w_goIdle) begin
      r_bitCnt    <= '0;
      r_frameDone <= 1'b0;
      r_miso      <= 1'b0;
      r_misoOe    <= 1'b0;
    end else if (w_load) begin
      r_txShift   <= bus.tx_valid ? bus.tx_data : '1;
      r_miso      <= bus.tx_valid ? bus.tx_data[DATA_WIDTH-1] : 1'b1;
      r_misoOe    <= 1'b1;
      r_bitCnt    <= '0;
      r_frameDone <= 1'b0;
    end else if (w_shiftOut) begin
      r_txShift <= r_txShift << 1;
      r_miso    <= r_txShift[DATA_WIDTH-2];
    end else if (w_sampleIn) begin
      r_rxShift <= w_rxByte;
      if (w_push) begin
        r_bitCnt    <= '0;
        r_frameDone <= 1'b1;
      end else begin
        r_bitCnt <= r_bitCnt + 1'b1;
      end
    end
  end

`ifdef SPIS_RXFIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [PW:0]           r_count;
  logic                  w_full;

  assign w_full    = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_rxValid = (r_count != '0);
  assign w_pop     = w_rxValid & bus.rx_ready;
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_rxHead  = r_mem[r_rdPtr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wrPtr] <= w_rxByte;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end
`else
  logic [DATA_WIDTH-1:0] r_rxData;
  logic                  r_rxValid;

  assign w_rxValid = r_rxValid;
  assign w_pop     = r_rxValid & bus.rx_ready;
  assign w_accept  = w_push & (~r_rxValid | w_pop);
  assign w_rxHead  = r_rxData;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rxData  <= '0;
      r_rxValid <= 1'b0;
    end else if (w_accept) begin
      r_rxData  <= w_rxByte;
      r_rxValid <= 1'b1;
    end else if (w_pop) begin
      r_rxValid <= 1'b0;
    end
  end
`endif

  assign w_drop = w_push & ~w_accept;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.rx_ready && !w_rxValid) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_unused = r_rxShift[DATA_WIDTH-1] ^ (FIFO_DEPTH > 0);

  assign bus.miso_o      = r_miso;
  assign bus.miso_oe_o   = r_misoOe;
  assign bus.tx_ready    = w_txReady;
  assign bus.tx_underrun = w_txUnderrun;
  assign bus.rx_data     = w_rxHead;
  assign bus.rx_valid    = w_rxValid;
  assign bus.rx_overflow = r_overflow;
  assign bus.busy        = ~w_ssS;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: drives a mode-0 master at clk/10 and checks
// MISO bytes, RX handshakes, tx_ready/tx_underrun pulse counts, abort, overflow and async reset.
module tb_spi_slave_resp;

  localparam int HP = 5;

  logic clk;
  logic nrst;

  int nVectors;
  int nMiscompares;

  int txReadyCnt;
  int txUnderrunCnt;
  logic [7:0] popQ[$];

  spi_slave_resp_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_resp #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and pop monitor, sampled mid-cycle so it sees what the next posedge acts on.
  initial begin
    txReadyCnt    = 0;
    txUnderrunCnt = 0;
  end
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.tx_ready)    txReadyCnt    = txReadyCnt + 1;
      if (bus.tx_underrun) txUnderrunCnt = txUnderrunCnt + 1;
      if (bus.rx_valid && bus.rx_ready) popQ.push_back(bus.rx_data);
    end
  end

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp)
    else begin
      nMiscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master: MOSI set while sck low, MISO sampled at the rise; on the last
  // bit of a transfer ss is raised together with the final sck fall.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits, input bit first,
                               input bit last, input logic [7:0] nextTx,
                               output logic [7:0] misoByte, output int rxLat);
    misoByte = '0;
    rxLat    = 99;
    if (first) begin
      bus.ss_n_i = 1'b0;
      stepClk(HP);
    end
    for (int i = 0; i < nBits; i++) begin
      bus.mosi_i = mosiByte[7-i];
      stepClk(HP);
      bus.sck_i = 1'b1;
      misoByte[7-i] = bus.miso_o;
      if (i == nBits - 1) bus.tx_data = nextTx;
      for (int k = 1; k <= HP; k++) begin
        stepClk(1);
        if (i == nBits - 1 && bus.rx_valid && rxLat == 99) rxLat = k;
      end
      if (i == nBits - 1 && last) bus.ss_n_i = 1'b1;
      bus.sck_i = 1'b0;
    end
    if (last) stepClk(2 * HP);
  endtask

  task automatic popFor(input int n);
    bus.rx_ready = 1'b1;
    stepClk(n);
    bus.rx_ready = 1'b0;
    stepClk(1);
  endtask

  initial begin
    logic [7:0] m;
    int         lat;
    int         rdyBase;
    int         undBase;
    int         qBase;

    nVectors     = 0;
    nMiscompares = 0;
    nrst         = 1'b0;
    bus.sck_i    = 1'b0;
    bus.mosi_i   = 1'b0;
    bus.ss_n_i   = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    #12;
    checkOutput("rst_miso",     bus.miso_o,      0);
    checkOutput("rst_oe",       bus.miso_oe_o,   0);
    checkOutput("rst_txready",  bus.tx_ready,    0);
    checkOutput("rst_rxdata",   bus.rx_data,     0);
    checkOutput("rst_rxvalid",  bus.rx_valid,    0);
    checkOutput("rst_overflow", bus.rx_overflow, 0);
    checkOutput("rst_underrun", bus.tx_underrun, 0);
    checkOutput("rst_busy",     bus.busy,        0);
    stepClk(2);
    nrst = 1'b1;
    stepClk(3);

    $display("[TB] single frame");
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    rdyBase = txReadyCnt;
    undBase = txUnderrunCnt;
    applyStimulus(8'h3C, 8, 1, 1, 8'hA5, m, lat);
    checkOutput("single_miso",     m, 8'hA5);
    checkOutput("single_rxdata",   bus.rx_data, 8'h3C);
    checkOutput("single_rxvalid",  bus.rx_valid, 1);
    checkOutput("single_latency",  (lat >= 1 && lat <= 4), 1);
    checkOutput("single_txready",  txReadyCnt - rdyBase, 1);
    checkOutput("single_underrun", txUnderrunCnt - undBase, 0);
    checkOutput("single_oe_off",   bus.miso_oe_o, 0);
    checkOutput("single_busy_off", bus.busy, 0);
    popFor(1);
    checkOutput("single_popped", bus.rx_valid, 0);

    $display("[TB] back-to-back frames");
    bus.tx_data  = 8'h11;
    rdyBase = txReadyCnt;
    undBase = txUnderrunCnt;
    qBase   = popQ.size();
    bus.rx_ready = 1'b1;
    applyStimulus(8'h01, 8, 1, 0, 8'h22, m, lat);
    checkOutput("b2b_miso0", m, 8'h11);
    applyStimulus(8'h02, 8, 0, 0, 8'h33, m, lat);
    checkOutput("b2b_miso1", m, 8'h22);
    applyStimulus(8'h03, 8, 0, 1, 8'h33, m, lat);
    checkOutput("b2b_miso2", m, 8'h33);
    bus.rx_ready = 1'b0;
    stepClk(1);
    checkOutput("b2b_txready",  txReadyCnt - rdyBase, 3);
    checkOutput("b2b_underrun", txUnderrunCnt - undBase, 0);
    checkOutput("b2b_npop",     popQ.size() - qBase, 3);
    if (popQ.size() - qBase == 3) begin
      checkOutput("b2b_rx0", popQ[qBase],     8'h01);
      checkOutput("b2b_rx1", popQ[qBase + 1], 8'h02);
      checkOutput("b2b_rx2", popQ[qBase + 2], 8'h03);
    end
    checkOutput("b2b_overflow", bus.rx_overflow, 0);

    $display("[TB] underrun");
    bus.tx_valid = 1'b0;
    rdyBase = txReadyCnt;
    undBase = txUnderrunCnt;
    applyStimulus(8'h96, 8, 1, 1, 8'h00, m, lat);
    checkOutput("und_miso",     m, 8'hFF);
    checkOutput("und_pulses",   txUnderrunCnt - undBase, 1);
    checkOutput("und_txready",  txReadyCnt - rdyBase, 0);
    checkOutput("und_rxdata",   bus.rx_data, 8'h96);
    checkOutput("und_rxvalid",  bus.rx_valid, 1);
    popFor(1);

    $display("[TB] abort");
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hC3;
    rdyBase = txReadyCnt;
    applyStimulus(8'hF0, 5, 1, 1, 8'hC3, m, lat);
    checkOutput("abort_rxvalid", bus.rx_valid, 0);
    checkOutput("abort_oe",      bus.miso_oe_o, 0);
    checkOutput("abort_miso",    bus.miso_o, 0);
    checkOutput("abort_txready", txReadyCnt - rdyBase, 1);
    applyStimulus(8'h5A, 8, 1, 1, 8'hC3, m, lat);
    checkOutput("abort_next_rx",   bus.rx_data, 8'h5A);
    checkOutput("abort_next_miso", m, 8'hC3);
    popFor(1);

    $display("[TB] overflow");
    qBase = popQ.size();
`ifdef SPIS_RXFIFO_EN
    for (int f = 0; f < 5; f++) begin
      applyStimulus(8'h10 + 8'(f), 8, 1, 1, 8'hC3, m, lat);
    end
    checkOutput("ovf_flag",    bus.rx_overflow, 1);
    checkOutput("ovf_head",    bus.rx_data, 8'h10);
    checkOutput("ovf_rxvalid", bus.rx_valid, 1);
    popFor(6);
    checkOutput("ovf_npop", popQ.size() - qBase, 4);
    if (popQ.size() - qBase == 4) begin
      for (int j = 0; j < 4; j++) begin
        checkOutput("ovf_fifo_entry", popQ[qBase + j], 8'h10 + 8'(j));
      end
    end
`else
    applyStimulus(8'h10, 8, 1, 1, 8'hC3, m, lat);
    applyStimulus(8'h11, 8, 1, 1, 8'hC3, m, lat);
    checkOutput("ovf_flag",    bus.rx_overflow, 1);
    checkOutput("ovf_head",    bus.rx_data, 8'h10);
    checkOutput("ovf_rxvalid", bus.rx_valid, 1);
    popFor(6);
    checkOutput("ovf_npop", popQ.size() - qBase, 1);
    if (popQ.size() - qBase == 1) begin
      checkOutput("ovf_popped", popQ[qBase], 8'h10);
    end
`endif
    checkOutput("ovf_cleared", bus.rx_overflow, 0);
    checkOutput("ovf_empty",   bus.rx_valid, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hE7, 4, 1, 0, 8'hA5, m, lat);
    stepClk(4);
    checkOutput("mid_busy", bus.busy, 1);
    checkOutput("mid_oe",   bus.miso_oe_o, 1);
    nrst = 1'b0;
    #1;
    checkOutput("arst_miso",     bus.miso_o, 0);
    checkOutput("arst_oe",       bus.miso_oe_o, 0);
    checkOutput("arst_busy",     bus.busy, 0);
    checkOutput("arst_rxvalid",  bus.rx_valid, 0);
    checkOutput("arst_rxdata",   bus.rx_data, 0);
    checkOutput("arst_txready",  bus.tx_ready, 0);
    checkOutput("arst_underrun", bus.tx_underrun, 0);
    bus.ss_n_i = 1'b1;
    bus.sck_i  = 1'b0;
    bus.mosi_i = 1'b0;
    stepClk(2);
    nrst = 1'b1;
    stepClk(3);
    bus.tx_data = 8'h88;
    applyStimulus(8'h77, 8, 1, 1, 8'h88, m, lat);
    checkOutput("post_rst_rx",      bus.rx_data, 8'h77);
    checkOutput("post_rst_rxvalid", bus.rx_valid, 1);
    checkOutput("post_rst_miso",    m, 8'h88);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
